// File: rtl/spill_register.sv
// spill_register: two-entry elastic buffer, full throughput, no comb path ready_i -> ready_o
module spill_register #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  logic a_full_q, b_full_q, a_fill, a_drain, b_fill, b_drain;
  T a_data_q, b_data_q;
  assign a_fill  = valid_i && ready_o;
  assign a_drain = a_full_q && !b_full_q;
  assign b_fill  = a_drain && !ready_i;
  assign b_drain = b_full_q && ready_i;
  assign ready_o = !a_full_q || !b_full_q;
  assign valid_o = a_full_q || b_full_q;
  assign data_o  = b_full_q ? b_data_q : a_data_q;
  // entry a takes new data; it spills into b when the consumer stalls
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_fill || a_drain) a_full_q <= a_fill;
      if (a_fill) a_data_q <= data_i;
      if (b_fill || b_drain) b_full_q <= b_fill;
      if (b_fill) b_data_q <= a_data_q;
    end
endmodule

// File: rtl/rr_arb_tree.sv
// rr_arb_tree: round-robin arbiter with lock-in; RR_ARB_TREE_OUT_SPILL_EN adds an output spill stage
module rr_arb_tree #(
  parameter int unsigned NumIn = 4,
  parameter type DataType = logic,
  parameter bit ExtPrio = 1'b0,
  parameter bit AxiVldRdy = 1'b0,
  parameter bit LockIn = 1'b0,
  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [IdxW-1:0] rr_i,
  input  logic [NumIn-1:0] req_i,
  output logic [NumIn-1:0] gnt_o,
  input  DataType         data_i [NumIn],
  output logic            req_o,
  input  logic            gnt_i,
  output DataType         data_o,
  output logic [IdxW-1:0] idx_o
);
  logic [IdxW-1:0] ptr_q, lock_idx_q, prio, sel, idx;
  logic lock_q, locked, arb_valid, arb_ready, hs;
  assign prio      = ExtPrio ? ((32'(rr_i) >= NumIn) ? '0 : rr_i) : ptr_q;
  assign locked    = LockIn && lock_q && req_i[lock_idx_q];
  assign idx       = (NumIn == 1) ? '0 : locked ? lock_idx_q : sel;
  assign arb_valid = |req_i;
  assign hs        = arb_valid && arb_ready;
  // lowest requester at or above the pointer, else the lowest requester overall
  always_comb begin
    sel = '0;
    for (int i = NumIn - 1; i >= 0; i--) if (req_i[i]) sel = IdxW'(i);
    for (int i = NumIn - 1; i >= 0; i--) if (req_i[i] && IdxW'(i) >= prio) sel = IdxW'(i);
  end
  for (genvar k = 0; k < NumIn; k++) begin : g_gnt
    assign gnt_o[k] = arb_ready && (idx == IdxW'(k)) && (AxiVldRdy || req_i[k]);
  end
  // pointer moves just past the winner on each handshake; flush beats the update
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr_q <= '0;
    else if (flush_i) ptr_q <= '0;
    else if (hs && NumIn > 1) ptr_q <= (idx == IdxW'(NumIn - 1)) ? '0 : idx + 1'b1;
  // a stalled winner is held until it handshakes or withdraws its request
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
    end else begin
      lock_q     <= LockIn && arb_valid && !arb_ready;
      lock_idx_q <= idx;
    end
`ifdef RR_ARB_TREE_OUT_SPILL_EN
  typedef struct packed {
    DataType         d;
    logic [IdxW-1:0] i;
  } spill_t;
  spill_t spill_in, spill_out;
  assign spill_in = '{d: data_i[idx], i: idx};
  spill_register #(.T(spill_t)) i_spill (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (arb_valid),
    .ready_o (arb_ready),
    .data_i  (spill_in),
    .valid_o (req_o),
    .ready_i (gnt_i),
    .data_o  (spill_out)
  );
  assign data_o = spill_out.d;
  assign idx_o  = spill_out.i;
`else
  assign arb_ready = gnt_i;
  assign req_o     = arb_valid;
  assign data_o    = data_i[idx];
  assign idx_o     = idx;
`endif
endmodule

// File: tb/tb_rr_arb_tree.sv
// tb_rr_arb_tree: vector table, lock/axi/flush/reset sequences and randomized model check
module tb_rr_arb_tree;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, gnt = 1'b0;
  logic [1:0] rr = '0;
  logic [3:0] req = '0;
  logic [7:0] data [4];
  logic [3:0] gnt_o0, gnt_o1;
  logic req_o0, req_o1;
  logic [7:0] data_o0, data_o1;
  logic [1:0] idx_o0, idx_o1;
  int pass = 0, total = 0;
  int p0, l0, p1, l1, w0, w1;
  logic [3:0] g0, g1;
  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       flush;
    logic [1:0] idx;
    logic [3:0] go;
    logic       ro;
  } vec_t;
  vec_t tbl [17];

  always #5 clk = ~clk;

  rr_arb_tree #(.NumIn(4), .DataType(logic [7:0])) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(rr), .req_i(req), .gnt_o(gnt_o0),
    .data_i(data), .req_o(req_o0), .gnt_i(gnt), .data_o(data_o0), .idx_o(idx_o0)
  );
  rr_arb_tree #(.NumIn(4), .DataType(logic [7:0]), .LockIn(1'b1), .AxiVldRdy(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(rr), .req_i(req), .gnt_o(gnt_o1),
    .data_i(data), .req_o(req_o1), .gnt_i(gnt), .data_o(data_o1), .idx_o(idx_o1)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask

  task automatic drive(input logic [3:0] r, input logic g, input logic f);
    req = r;
    gnt = g;
    flush = f;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // winner = first requester walking upward from the pointer (mod 4), lock first
  task automatic model(input int ptr, input int lk, input bit axi, input logic [3:0] r,
                       input logic g, output int w, output logic [3:0] go);
    w = 0;
    if (lk >= 0 && r[lk]) w = lk;
    else for (int j = 3; j >= 0; j--) if (r[(ptr + j) % 4]) w = (ptr + j) % 4;
    go = '0;
    if (g && (axi || r[w])) go[w] = 1'b1;
  endtask

  task automatic upd(inout int ptr, inout int lk, input bit lockin, input int w,
                     input logic [3:0] r, input logic g, input logic f);
    if (f) begin
      ptr = 0;
      lk = -1;
    end else begin
      if (|r && g) ptr = (w + 1) % 4;
      lk = (lockin && |r && !g) ? w : -1;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) data[k] = 8'hA0 + 8'(k);
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 2'd3, 4'b1000, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1};
    tbl[5]  = '{4'b0010, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
    tbl[6]  = '{4'b0011, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
    tbl[8]  = '{4'b1110, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[10] = '{4'b1011, 1'b1, 1'b0, 2'd3, 4'b1000, 1'b1};
    tbl[11] = '{4'b1010, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
    tbl[12] = '{4'b0100, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0};
    tbl[14] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1};
    tbl[15] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1};
    tbl[16] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1};
    // reset state, including AXI-style grant with no request
    drive(4'b0000, 1'b1, 1'b0);
    chk("rst idx", 32'(idx_o0), 0);
    chk("rst req_o", 32'(req_o0), 0);
    chk("rst gnt_o", 32'(gnt_o0), 0);
    chk("rst axi gnt_o", 32'(gnt_o1), 32'b0001);
    chk("rst data", 32'(data_o0), 32'hA0);
    drive(4'b1111, 1'b1, 1'b0);
    chk("rst busy idx", 32'(idx_o1), 0);
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].flush);
      chk($sformatf("vec%0d idx", i), 32'(idx_o0), 32'(tbl[i].idx));
      chk($sformatf("vec%0d gnt", i), 32'(gnt_o0), 32'(tbl[i].go));
      chk($sformatf("vec%0d req_o", i), 32'(req_o0), 32'(tbl[i].ro));
      chk($sformatf("vec%0d data", i), 32'(data_o0), 32'(8'hA0 + 8'(tbl[i].idx)));
      tick;
    end
    // lock-in sequence on dut1
    drive(4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0110, 1'b0, 1'b0);
      chk("lock stall idx", 32'(idx_o1), 1);
      tick;
    end
    drive(4'b0111, 1'b0, 1'b0);
    chk("lock hold idx", 32'(idx_o1), 1);
    tick;
    drive(4'b0111, 1'b1, 1'b0);
    chk("lock hs idx", 32'(idx_o1), 1);
    chk("lock hs gnt", 32'(gnt_o1), 32'b0010);
    tick;
    drive(4'b0111, 1'b0, 1'b0);
    chk("lock next idx", 32'(idx_o1), 2);
    tick;
    drive(4'b0000, 1'b1, 1'b0);
    chk("axi gnt_o", 32'(gnt_o1), 32'b0001);
    chk("axi req_o", 32'(req_o1), 0);
    tick;
    drive(4'b1111, 1'b0, 1'b0);
    chk("axi ptr kept", 32'(idx_o1), 2);
    tick;
    drive(4'b1011, 1'b0, 1'b0);
    chk("lock drop idx", 32'(idx_o1), 3);
    tick;
    drive(4'b0100, 1'b0, 1'b0);
    chk("lock2 idx", 32'(idx_o1), 2);
    tick;
    drive(4'b1111, 1'b0, 1'b0);
    chk("lock2 hold", 32'(idx_o1), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst mid-lock idx", 32'(idx_o1), 0);
    tick;
    rst = 1'b0;
    #1;
    chk("post-rst idx", 32'(idx_o1), 0);
    tick;
    // randomized run against the reference model
    rst = 1'b1;
    tick;
    rst = 1'b0;
    p0 = 0; l0 = -1; p1 = 0; l1 = -1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) data[k] = 8'($urandom);
      rr = 2'($urandom);
      drive(4'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0);
      model(p0, l0, 1'b0, req, gnt, w0, g0);
      model(p1, l1, 1'b1, req, gnt, w1, g1);
      chk("rnd0 idx", 32'(idx_o0), 32'(w0));
      chk("rnd0 gnt", 32'(gnt_o0), 32'(g0));
      chk("rnd0 req_o", 32'(req_o0), 32'(|req));
      chk("rnd0 data", 32'(data_o0), 32'(data[w0]));
      chk("rnd1 idx", 32'(idx_o1), 32'(w1));
      chk("rnd1 gnt", 32'(gnt_o1), 32'(g1));
      chk("rnd1 req_o", 32'(req_o1), 32'(|req));
      chk("rnd1 data", 32'(data_o1), 32'(data[w1]));
      @(posedge clk);
      upd(p0, l0, 1'b0, w0, req, gnt, flush);
      upd(p1, l1, 1'b1, w1, req, gnt, flush);
      #1;
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/rr_arb_tree.md
RR_ARB_TREE -- requirements
Module: rr_arb_tree

Interface
REQ-001 The block SHALL take parameter NumIn, default 4, as the number of requesters (at least 1).
REQ-002 The block SHALL take parameter DataType, default logic, as the type of each payload.
REQ-003 The block SHALL take parameter ExtPrio, default 0: 1 = use rr_i as the priority pointer, 0 = use the internal pointer.
REQ-004 The block SHALL take parameter AxiVldRdy, default 0: 1 = gnt_o does not depend on req_i of the granted input.
REQ-005 The block SHALL take parameter LockIn, default 0: 1 = hold the winner until handshake.
REQ-006 The block SHALL have ports:
- clk_i, in, 1, the single clock.
- rst_i, in, 1, reset; asynchronous, active-high.
- flush_i, in, 1, synchronous clear of pointer and lock.
- rr_i, in, IdxW, external priority pointer.
- req_i, in, NumIn, per-input valid.
- gnt_o, out, NumIn, per-input ready.
- data_i, in, NumIn x DataType, per-input payload.
- req_o, out, 1, output valid.
- gnt_i, in, 1, output ready.
- data_o, out, DataType, selected payload.
- idx_o, out, IdxW, index of the selected input.
REQ-007 IdxW SHALL be max(1, clog2(NumIn)).

Function
REQ-008 req_o SHALL be the OR of req_i.
REQ-009 Selection: with pointer P, the winner SHALL be the lowest-index requesting input with index at least P; if there is none, the lowest-index requesting input.
REQ-010 With no request, idx_o SHALL be 0 and data_o SHALL be data_i[0].
REQ-011 data_o SHALL be data_i[idx_o]; the path is combinational, with zero latency when the output spill stage is not compiled in.
REQ-012 gnt_o[k] SHALL be gnt_i AND (k == idx_o) AND req_i[k] when AxiVldRdy=0.
REQ-013 gnt_o[k] SHALL be gnt_i AND (k == idx_o) when AxiVldRdy=1.
REQ-014 At most one gnt_o bit SHALL be high in any cycle.
REQ-015 Handshake is req_o AND gnt_i.
REQ-016 ExtPrio=0: on each handshake the internal pointer SHALL become idx_o+1, wrapping from NumIn-1 to 0; without a handshake it holds.
REQ-017 ExtPrio=1: P SHALL be rr_i and the internal pointer is unused; an rr_i value of NumIn or more is treated as 0.
REQ-018 LockIn=1 and req_o=1 and gnt_i=0: the lock SHALL be set and store idx_o.
REQ-019 While locked, the winner SHALL be the locked index regardless of higher-priority requests.
REQ-020 The lock SHALL clear on the handshake cycle.
REQ-021 If the locked input drops its request, the lock SHALL release in that cycle and normal selection applies.
REQ-022 LockIn=0: the winner MAY change while gnt_i is low.
REQ-023 NumIn=1: the block SHALL be a pass-through (req_o=req_i[0], gnt_o[0] per REQ-012/013, idx_o=0) and the pointer is constant 0.
REQ-024 flush_i=1: the pointer SHALL become 0 and the lock SHALL clear at the next clock edge; flush_i has priority over a simultaneous handshake update.
REQ-025 Outputs remain combinational while flush_i is high.

Reset
REQ-026 rst_i=1 SHALL asynchronously set the pointer to 0 and clear the lock.
REQ-027 During reset, outputs SHALL follow REQ-008..013 with P=0.
REQ-028 When the output spill stage is compiled in, its storage SHALL also be emptied by reset, giving req_o=0.
REQ-029 Reset asserted mid-transfer SHALL drop any held selection; a new arbitration starts after release.

Configuration
REQ-030 RR_ARB_TREE_OUT_SPILL_EN defined: req_o/data_o/idx_o SHALL pass through a spill_register stage.
- The stage stores up to 2 entries, gives full throughput, and has no combinational path from gnt_i to gnt_o.
- Output latency is 1 cycle.
- The internal handshake (pointer update and lock) uses the spill stage's ready instead of gnt_i.
REQ-031 RR_ARB_TREE_OUT_SPILL_EN undefined: the block SHALL be purely combinational from inputs to outputs apart from the pointer and lock registers.

Structure
REQ-032 No shared package SHALL be required; IdxW SHALL be a localparam inside the module.
REQ-033 The only sub-module SHALL be spill_register.
- Parameter T; ports clk_i, rst_i, valid_i, ready_o, data_i, valid_o, ready_i, data_o.
- Instantiated only under RR_ARB_TREE_OUT_SPILL_EN.
REQ-034 Pointer and lock SHALL be the only registers in the arbitration path.

Verification
REQ-035 All scenarios SHALL use NumIn=4, ExtPrio=0 and, unless stated, LockIn=0, AxiVldRdy=0.
REQ-036 Rotation: req_i=4'b1111 and gnt_i=1 for 5 cycles -> idx_o=0,1,2,3,0 and one-hot gnt_o each cycle.
REQ-037 Pointer skip: pointer=2, req_i=4'b0011 -> idx_o=0; after the handshake the pointer is 1.
REQ-038 Lock (LockIn=1): req_i=4'b0110 with gnt_i=0 for 3 cycles, then req_i=4'b0111 -> idx_o stays 1 until gnt_i=1 completes the handshake; next winner is 2.
REQ-039 AxiVldRdy=1 with req_i=0 and gnt_i=1 -> gnt_o=4'b0001, req_o=0, pointer unchanged.
REQ-040 flush_i pulse with pointer=3 -> pointer=0; req_i=4'b1111 -> idx_o=0.
REQ-041 Reset mid-lock (LockIn=1, idx 2 locked): assert rst_i -> lock cleared; after release, req_i=4'b1111 -> idx_o=0.
